// File: rtl/bottomhalf_bus_master_pkg.sv
// Shared types and constants for the bottom-half bus master.
// Also carries register addresses of the bottom-half FPGA ID block.
package bottomhalf_bus_pkg;

  typedef enum logic [3:0] {
    IDLE,
    A_SETUP,
    A_STROBE,
    A_HOLD,
    W_SETUP,
    W_STROBE,
    W_HOLD,
    R_TURN,
    R_STROBE,
    R_RECOVER
  } state_e;

  localparam int unsigned ADDR_OK_BIT = 4;

  localparam logic [7:0] ID_MAJOR_LO_ADDR = 8'hFD;
  localparam logic [7:0] ID_MAJOR_HI_ADDR = 8'hFE;

endpackage

// File: rtl/bottomhalf_bus_master_if.sv
// Request handshake plus multiplexed bottom-half bus.
// master = bus master block, slave = requester and bottom-half FPGA.
interface bottomhalf_bus_master_if;

  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       done;
  logic [7:0] rdata;
  logic       bus_ale;
  logic       bus_write;
  logic       bus_read;
  logic [7:0] bus_dout;
  logic       bus_oe;
  logic [7:0] bus_din;

  modport master (
    input  req_valid,
    input  req_write,
    input  req_addr,
    input  req_wdata,
    input  bus_din,
    output req_ready,
    output done,
    output rdata,
    output bus_ale,
    output bus_write,
    output bus_read,
    output bus_dout,
    output bus_oe
  );

  modport slave (
    output req_valid,
    output req_write,
    output req_addr,
    output req_wdata,
    output bus_din,
    input  req_ready,
    input  done,
    input  rdata,
    input  bus_ale,
    input  bus_write,
    input  bus_read,
    input  bus_dout,
    input  bus_oe
  );

endinterface

// File: rtl/bottomhalf_bus_master_bus_phase_timer.sv
// Loadable 8-bit down-counter timing every bus phase.
// Stops at zero; zero_o marks the last cycle of a phase.
module bus_phase_timer (
  input  logic       osc,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic       zero_o
);

  logic [7:0] cnt_q;

  always_ff @(posedge osc) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != 8'd0) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  assign zero_o = (cnt_q == 8'd0);

endmodule

// File: rtl/bottomhalf_bus_master.sv
// Strobed 8-bit bus master: address latch phase, then write or read.
// A one-entry address cache lets repeat accesses skip the ALE phase.
module bottomhalf_bus_master
  import bottomhalf_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned STROBE_CYCLES = 4,
  parameter bit          ADDR_CACHE    = 1'b1
) (
  input  logic                    osc,
  input  logic                    rst,
  bottomhalf_bus_master_if.master bus
);

  localparam logic [7:0] S_LD = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] T_LD = 8'(STROBE_CYCLES - 1);

  state_e     state_q, state_d;
  logic       ld;
  logic [7:0] ld_val;
  logic       zero;

  logic       ready_q, done_q;
  logic       ale_q, wr_n_q, rd_n_q, oe_q;
  logic [7:0] dout_q, rdata_q;
  logic [7:0] addr_q, wdata_q;
  logic       wr_q;
  logic [7:0] cache_q;
  logic       cache_vld_q;

  logic accept;
  logic hit;

  assign accept = bus.req_valid && ready_q;
  assign hit    = ADDR_CACHE && cache_vld_q
               && (bus.req_addr == cache_q);

  bus_phase_timer u_timer (
    .osc        (osc),
    .rst        (rst),
    .load_i     (ld),
    .load_val_i (ld_val),
    .zero_o     (zero)
  );

  // Each phase loads its length minus one on entry.
  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    ld_val  = 8'd0;
    unique case (state_q)
      IDLE: if (accept) begin
        ld = 1'b1;
        if (!hit) begin
          state_d = A_SETUP;
          ld_val  = S_LD;
        end else if (bus.req_write) begin
          state_d = W_SETUP;
          ld_val  = S_LD;
        end else begin
          state_d = R_TURN;
        end
      end
      A_SETUP: if (zero) begin
        state_d = A_STROBE;
        ld      = 1'b1;
        ld_val  = T_LD;
      end
      A_STROBE: if (zero) begin
        state_d = A_HOLD;
        ld      = 1'b1;
      end
      A_HOLD: if (zero) begin
        ld = 1'b1;
        if (wr_q) begin
          state_d = W_SETUP;
          ld_val  = S_LD;
        end else begin
          state_d = R_TURN;
        end
      end
      W_SETUP: if (zero) begin
        state_d = W_STROBE;
        ld      = 1'b1;
        ld_val  = T_LD;
      end
      W_STROBE: if (zero) begin
        state_d = W_HOLD;
        ld      = 1'b1;
      end
      W_HOLD: if (zero) begin
        state_d = IDLE;
        ld      = 1'b1;
      end
      R_TURN: if (zero) begin
        state_d = R_STROBE;
        ld      = 1'b1;
        ld_val  = T_LD;
      end
      R_STROBE: if (zero) begin
        state_d = R_RECOVER;
        ld      = 1'b1;
      end
      R_RECOVER: if (zero) begin
        state_d = IDLE;
        ld      = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge osc) begin
    if (rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      ale_q       <= 1'b0;
      wr_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      oe_q        <= 1'b0;
      dout_q      <= 8'd0;
      rdata_q     <= 8'd0;
      addr_q      <= 8'd0;
      wdata_q     <= 8'd0;
      wr_q        <= 1'b0;
      cache_q     <= 8'd0;
      cache_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == IDLE);
      done_q  <= (state_d == IDLE)
              && (state_q == W_HOLD
               || state_q == R_RECOVER);
      ale_q   <= (state_d == A_STROBE);
      wr_n_q  <= (state_d != W_STROBE);
      rd_n_q  <= (state_d != R_STROBE);
      oe_q    <= state_d inside {
                   A_SETUP, A_STROBE, A_HOLD,
                   W_SETUP, W_STROBE, W_HOLD};
      if (state_q == IDLE && accept) begin
        addr_q  <= bus.req_addr;
        wr_q    <= bus.req_write;
        wdata_q <= bus.req_wdata;
        dout_q  <= (hit && bus.req_write)
                 ? bus.req_wdata : bus.req_addr;
      end
      if (state_q == A_HOLD && state_d != A_HOLD) begin
        cache_q     <= addr_q;
        cache_vld_q <= 1'b1;
        dout_q      <= wdata_q;
      end
      if (state_q == R_STROBE && state_d == R_RECOVER) begin
        rdata_q <= bus.bus_din;
      end
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.done      = done_q;
  assign bus.rdata     = rdata_q;
  assign bus.bus_ale   = ale_q;
  assign bus.bus_write = wr_n_q;
  assign bus.bus_read  = rd_n_q;
  assign bus.bus_dout  = dout_q;
  assign bus.bus_oe    = oe_q;

endmodule

// File: tb/tb_bottomhalf_bus_master.sv
// Scoreboard bench: stimulus pushes expectations, monitor pops on done.
// Includes a small bottom-half register model and a protocol checker.
module tb_bottomhalf_bus_master;
  import bottomhalf_bus_pkg::*;

  localparam int S = 2;
  localparam int T = 4;

  logic osc = 1'b0;
  logic rst = 1'b1;

  bottomhalf_bus_master_if bus();

  bottomhalf_bus_master #(
    .SETUP_CYCLES  (S),
    .STROBE_CYCLES (T),
    .ADDR_CACHE    (1'b1)
  ) dut (
    .osc (osc),
    .rst (rst),
    .bus (bus)
  );

  always #5 osc = ~osc;

  typedef struct {
    bit         wr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         lat;
    int         ales;
  } exp_t;

  exp_t sb[$];
  int   acc_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edges  = 0;
  int   ndone  = 0;
  int   ale_cnt = 0;
  int   wlow    = 0;
  int   dbad    = 0;
  logic       prev_ale  = 1'b0;
  logic       prev_wr   = 1'b1;
  logic [7:0] prev_dout = 8'd0;
  logic [7:0] lat_addr  = 8'd0;
  logic [7:0] mem [256];

  always @(posedge osc) edges++;

  // Bottom-half FPGA model
  always @(negedge bus.bus_ale) lat_addr = bus.bus_dout;
  always @(posedge bus.bus_write) mem[lat_addr] = bus.bus_dout;
  assign bus.bus_din = bus.bus_read ? 8'h00 : mem[lat_addr];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge osc);
    #2;
  endtask

  // Monitor: samples 3 time units after each falling edge.
  always @(negedge osc) begin : mon
    exp_t e;
    int   a;
    bit   viol;
    #3;
    if (rst) begin
      acc_q.delete();
      ale_cnt = 0;
      wlow    = 0;
      dbad    = 0;
    end else begin
      if (bus.bus_ale && !prev_ale) ale_cnt++;
      if (!bus.bus_write) begin
        wlow++;
        if (sb.size() > 0 && bus.bus_dout !== sb[0].wdata)
          dbad++;
      end
      if (bus.done) begin
        if (sb.size() == 0 || acc_q.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e = sb.pop_front();
          a = acc_q.pop_front();
          chk("latency", edges - a, e.lat);
          chk("ale_pulses", ale_cnt, e.ales);
          chk("wr_strobe_len", wlow, e.wr ? T : 0);
          chk("wr_data", dbad, 0);
          chk("rdata", int'(bus.rdata), int'(e.rdata));
        end
        ndone++;
        ale_cnt = 0;
        wlow    = 0;
        dbad    = 0;
      end
      if (bus.req_valid && bus.req_ready)
        acc_q.push_back(edges + 1);
    end
    viol = (int'(bus.bus_ale) + int'(!bus.bus_write)
            + int'(!bus.bus_read)) > 1;
    viol = viol || (bus.bus_oe && !bus.bus_read);
    if (!rst && (!bus.bus_write || !prev_wr)
        && bus.bus_dout !== prev_dout)
      viol = 1'b1;
    chk("protocol", int'(viol), 0);
    prev_ale  = bus.bus_ale;
    prev_wr   = bus.bus_write;
    prev_dout = bus.bus_dout;
  end

  task automatic issue(bit wr, logic [7:0] a,
                       logic [7:0] d, logic [7:0] rexp,
                       int lat, int ales, bit push);
    bit ok;
    ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    if (push) sb.push_back('{wr, d, rexp, lat, ales});
    for (int n = 0; n < 400 && !ok; n++) begin
      if (bus.req_ready) ok = 1'b1;
      tick();
    end
    if (!ok) chk("accept_timeout", 1, 0);
  endtask

  task automatic drain();
    for (int n = 0; n < 400 && sb.size() > 0; n++) tick();
    chk("drain", sb.size(), 0);
    tick();
  endtask

  task automatic single(bit wr, logic [7:0] a,
                        logic [7:0] d, logic [7:0] rexp,
                        int lat, int ales);
    issue(wr, a, d, rexp, lat, ales, 1'b1);
    bus.req_valid = 1'b0;
    drain();
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[ID_MAJOR_LO_ADDR] = 8'h34;
    mem[ID_MAJOR_HI_ADDR] = 8'h12;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 8'h00;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_ready", int'(bus.req_ready), 0);
    chk("rst_ale", int'(bus.bus_ale), 0);
    chk("rst_write", int'(bus.bus_write), 1);
    chk("rst_read", int'(bus.bus_read), 1);
    chk("rst_oe", int'(bus.bus_oe), 0);
    chk("rst_dout", int'(bus.bus_dout), 0);
    chk("rst_rdata", int'(bus.rdata), 0);
    chk("rst_done", int'(bus.done), 0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", int'(bus.req_ready), 1);

    // Directed single accesses
    single(1, 8'h12, 8'hA5, 8'h00, 14, 1);
    single(0, ID_MAJOR_LO_ADDR, 8'h00, 8'h34, 13, 1);
    single(1, 8'h12, 8'h5A, 8'h34, 14, 1);
    single(1, 8'h12, 8'hC3, 8'h34, 7, 0);
    single(1, 8'h13, 8'h0F, 8'h34, 14, 1);
    single(0, 8'h13, 8'h00, 8'h0F, 6, 0);
    single(0, 8'h12, 8'h00, 8'hC3, 13, 1);
    single(0, ID_MAJOR_HI_ADDR, 8'h00, 8'h12, 13, 1);
    single(1, ID_MAJOR_HI_ADDR, 8'h77, 8'h12, 7, 0);

    // req_valid held high across 8 requests
    issue(1, 8'h20, 8'h01, 8'h12, 14, 1, 1'b1);
    issue(1, 8'h20, 8'h02, 8'h12, 7, 0, 1'b1);
    issue(0, 8'h20, 8'h00, 8'h02, 6, 0, 1'b1);
    issue(1, 8'h21, 8'h03, 8'h02, 14, 1, 1'b1);
    issue(0, 8'h21, 8'h00, 8'h03, 6, 0, 1'b1);
    issue(0, 8'h20, 8'h00, 8'h02, 13, 1, 1'b1);
    issue(1, 8'h20, 8'h04, 8'h02, 7, 0, 1'b1);
    issue(0, 8'h20, 8'h00, 8'h04, 6, 0, 1'b1);
    bus.req_valid = 1'b0;
    drain();

    // Reset in the middle of the write strobe
    issue(1, 8'h55, 8'h99, 8'h00, 0, 0, 1'b0);
    bus.req_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      if (!bus.bus_write) seen = 1'b1;
      else tick();
    end
    chk("saw_write_strobe", int'(seen), 1);
    rst = 1'b1;
    tick();
    chk("abort_write", int'(bus.bus_write), 1);
    chk("abort_ale", int'(bus.bus_ale), 0);
    chk("abort_read", int'(bus.bus_read), 1);
    chk("abort_oe", int'(bus.bus_oe), 0);
    chk("abort_done", int'(bus.done), 0);
    tick();
    rst = 1'b0;
    for (int n = 0; n < 20; n++) tick();
    chk("ready_after_abort", int'(bus.req_ready), 1);
    single(1, 8'h55, 8'h99, 8'h00, 14, 1);
    single(0, 8'h55, 8'h00, 8'h99, 6, 0);

    chk("done_count", ndone, 19);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
